// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and status bit positions
// for the sequential ALU and its iterative multiplier.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_HOLD = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULT = 4'b1000;

   localparam int ST_Z = 3;
   localparam int ST_N = 2;
   localparam int ST_C = 1;
   localparam int ST_V = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one step per cycle,
// WIDTH steps; {o_hi,o_lo} holds the full product once busy drops.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic [WIDTH:0]   w_sum;

   // add the multiplicand into the high half when the next multiplier bit is set
   always_comb begin
      w_sum = {1'b0, r_hi};
      if (r_lo[0]) begin
         w_sum = {1'b0, r_hi} + {1'b0, r_a};
      end
   end

   // done marks the cycle whose edge performs the final step
   assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
   assign o_busy = r_busy;
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

   // load operands, then shift the product register right one bit per step
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_a    <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start && !r_busy) begin
         r_a    <= i_a;
         r_hi   <= '0;
         r_lo   <= i_b;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_hi  <= w_sum[WIDTH:1];
         r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + 1'b1;
         if (o_done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops and an optional
// iterative multiplier sequenced through IDLE/MUL/FIN.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [3:0]               i_op,
   input  logic [WIDTH-1:0]         i_a,
   input  logic [WIDTH-1:0]         i_b,
   input  logic [$clog2(WIDTH)-1:0] i_shamt,
   output logic [WIDTH-1:0]         o_result,
   output logic [WIDTH-1:0]         o_hi,
   output logic [3:0]               o_status,
   output logic                     o_busy,
   output logic                     o_done
);

   state_e           r_state;
   state_e           w_next;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_hi;
   logic [3:0]       r_status;
   logic             r_done;

   logic [WIDTH-1:0] w_bop;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;
   logic             w_legal;
   logic             w_mul_start;
   logic             w_mul_busy;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_hi;
   logic [WIDTH-1:0] w_mul_lo;

   // SUB and SLT share the adder as a + ~b + 1
   always_comb begin
      w_bop = i_b;
      w_cin = 1'b0;
      if (i_op == OP_SUB || i_op == OP_SLT) begin
         w_bop = ~i_b;
         w_cin = 1'b1;
      end
   end

   assign w_sum = {1'b0, i_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
   assign w_ovf = (i_a[WIDTH-1] == w_bop[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != i_a[WIDTH-1]);

   // single-cycle result and flag selection; MULT/HOLD are handled by the FSM
   always_comb begin
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      w_legal = 1'b1;
      case (i_op)
         OP_AND: w_res = i_a & i_b;
         OP_OR:  w_res = i_a | i_b;
         OP_ADD, OP_SUB: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = w_ovf;
         end
         OP_SLT: begin
            w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            w_c   = w_sum[WIDTH];
            w_v   = w_ovf;
         end
         OP_SLL: w_res = i_b << i_shamt;
         OP_SRL: w_res = i_b >> i_shamt;
         default: w_legal = 1'b0;
      endcase
   end

   // next state; a multiply is launched only from IDLE
   always_comb begin
      w_next      = r_state;
      w_mul_start = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && i_op == OP_MULT && MUL_EN != 0) begin
               w_mul_start = 1'b1;
               w_next      = S_MUL;
            end
         end
         S_MUL: begin
            if (w_mul_done) begin
               w_next = S_FIN;
            end
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // result/status/done registers, updated from IDLE requests or FIN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_result <= '0;
         r_hi     <= '0;
         r_status <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE && i_start && !w_mul_start) begin
            r_done <= 1'b1;
            if (i_op == OP_HOLD) begin
               r_result <= r_result;
            end else if (w_legal) begin
               r_result       <= w_res;
               r_status[ST_Z] <= ~|w_res;
               r_status[ST_N] <= w_res[WIDTH-1];
               r_status[ST_C] <= w_c;
               r_status[ST_V] <= w_v;
            end else begin
               r_result <= '0;
               r_status <= 4'b1000;
            end
         end else if (r_state == S_FIN) begin
            r_done         <= 1'b1;
            r_result       <= w_mul_lo;
            r_hi           <= w_mul_hi;
            r_status[ST_Z] <= ~|w_mul_lo;
            r_status[ST_N] <= w_mul_hi[WIDTH-1];
            r_status[ST_C] <= 1'b0;
            r_status[ST_V] <= 1'b0;
         end
      end
   end

   if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_start (w_mul_start),
         .i_a     (i_a),
         .i_b     (i_b),
         .o_busy  (w_mul_busy),
         .o_done  (w_mul_done),
         .o_hi    (w_mul_hi),
         .o_lo    (w_mul_lo)
      );
   end else begin : g_nomul
      assign w_mul_busy = 1'b0;
      assign w_mul_done = 1'b0;
      assign w_mul_hi   = '0;
      assign w_mul_lo   = '0;
   end

   assign o_result = r_result;
   assign o_hi     = r_hi;
   assign o_status = r_status;
   assign o_busy   = w_mul_busy;
   assign o_done   = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for a 32-bit instance with multiplier
// and an 8-bit instance without it.
module tb_alu_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        r32, s32;
   logic [3:0]  op32;
   logic [31:0] a32, b32;
   logic [4:0]  sh32;
   logic [31:0] res32, hi32;
   logic [3:0]  st32;
   logic        busy32, done32;

   logic        r8, s8;
   logic [3:0]  op8;
   logic [7:0]  a8, b8;
   logic [2:0]  sh8;
   logic [7:0]  res8, hi8;
   logic [3:0]  st8;
   logic        busy8, done8;

   int n_chk = 0;
   int n_err = 0;

   alu_seq #(.WIDTH(32), .MUL_EN(1)) u_dut32 (
      .i_clk(clk), .i_reset(r32), .i_start(s32), .i_op(op32),
      .i_a(a32), .i_b(b32), .i_shamt(sh32),
      .o_result(res32), .o_hi(hi32), .o_status(st32),
      .o_busy(busy32), .o_done(done32)
   );

   alu_seq #(.WIDTH(8), .MUL_EN(0)) u_dut8 (
      .i_clk(clk), .i_reset(r8), .i_start(s8), .i_op(op8),
      .i_a(a8), .i_b(b8), .i_shamt(sh8),
      .o_result(res8), .o_hi(hi8), .o_status(st8),
      .o_busy(busy8), .o_done(done8)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic go32(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
      @(negedge clk);
      op32 = o; a32 = a; b32 = b; sh32 = sh; s32 = 1'b1;
      @(negedge clk);
      s32 = 1'b0;
   endtask

   task automatic go8(input logic [3:0] o, input logic [7:0] a,
                      input logic [7:0] b);
      @(negedge clk);
      op8 = o; a8 = a; b8 = b; sh8 = '0; s8 = 1'b1;
      @(negedge clk);
      s8 = 1'b0;
   endtask

   initial begin
      int k;
      int nb;
      int nd;
      r32 = 1'b1; s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; sh32 = '0;
      r8  = 1'b1; s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0; sh8  = '0;
      repeat (3) @(negedge clk);
      r32 = 1'b0; r8 = 1'b0;

      check("rst_res", res32, 0);
      check("rst_hi", hi32, 0);
      check("rst_st", st32, 0);
      check("rst_busy", busy32, 0);
      check("rst_done", done32, 0);
      check("rst8_res", res8, 0);

      go32(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0);
      check("add_res", res32, 32'h8000_0000);
      check("add_st", st32, 4'b0101);
      check("add_done", done32, 1);
      @(negedge clk);
      check("add_done_pulse", done32, 0);

      go32(4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0);
      check("addc_res", res32, 0);
      check("addc_st", st32, 4'b1010);

      go32(4'b0110, 32'd5, 32'd5, 5'd0);
      check("sub_res", res32, 0);
      check("sub_st", st32, 4'b1010);

      go32(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd0);
      check("slt_res", res32, 1);
      go32(4'b0111, 32'h1, 32'hFFFF_FFFF, 5'd0);
      check("slt_res0", res32, 0);

      go32(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
      check("and_res", res32, 32'h00F0_1234);
      go32(4'b0001, 32'hF000_0000, 32'h0000_0001, 5'd0);
      check("or_res", res32, 32'hF000_0001);
      check("or_st", st32, 4'b0100);

      go32(4'b1111, 32'h5, 32'h6, 5'd0);
      check("ill_res", res32, 0);
      check("ill_st", st32, 4'b1000);
      check("ill_done", done32, 1);

      @(negedge clk);
      op32 = 4'b1000; a32 = 32'hFFFF_FFFF; b32 = 32'd2; s32 = 1'b1;
      @(negedge clk);
      s32 = 1'b0;
      k = 0;
      nb = 0;
      while (k < 100 && !done32) begin
         if (busy32) nb++;
         if (k == 3 || k == 10 || k == 17) begin
            s32 = 1'b1; op32 = 4'b0010; a32 = k; b32 = k;
         end else begin
            s32 = 1'b0; a32 = a32 ^ k; b32 = b32 + 1;
         end
         @(negedge clk);
         k++;
      end
      s32 = 1'b0;
      check("mul_latency", k, 33);
      check("mul_busy_cycles", nb, 32);
      check("mul_res", res32, 32'hFFFF_FFFE);
      check("mul_hi", hi32, 32'h1);
      check("mul_st", st32, 4'b0000);
      check("mul_busy_end", busy32, 0);
      @(negedge clk);
      check("mul_done_pulse", done32, 0);

      go32(4'b0011, 32'h0, 32'h1, 5'd31);
      check("sll_res", res32, 32'h8000_0000);
      check("sll_st", st32, 4'b0100);
      check("sll_hi_keep", hi32, 32'h1);
      go32(4'b0101, 32'h123, 32'h456, 5'd3);
      check("hold_res", res32, 32'h8000_0000);
      check("hold_st", st32, 4'b0100);
      check("hold_hi", hi32, 32'h1);
      check("hold_done", done32, 1);
      go32(4'b0100, 32'h0, 32'h8000_0000, 5'd4);
      check("srl_res", res32, 32'h0800_0000);
      check("srl_st", st32, 4'b0000);

      @(negedge clk);
      op32 = 4'b1000; a32 = 32'd3; b32 = 32'd4; s32 = 1'b1;
      @(negedge clk);
      s32 = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_pre", busy32, 1);
      r32 = 1'b1; s32 = 1'b1; op32 = 4'b0010; a32 = 32'd2; b32 = 32'd3;
      @(negedge clk);
      r32 = 1'b0; s32 = 1'b0;
      check("abort_res", res32, 0);
      check("abort_hi", hi32, 0);
      check("abort_st", st32, 0);
      check("abort_busy", busy32, 0);
      check("abort_done", done32, 0);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32 || busy32) nd++;
      end
      check("abort_quiet", nd, 0);
      go32(4'b0010, 32'd2, 32'd3, 5'd0);
      check("post_add_res", res32, 5);
      check("post_add_done", done32, 1);

      go8(4'b0010, 8'h7F, 8'h01);
      check("w8_add_res", res8, 8'h80);
      check("w8_add_st", st8, 4'b0101);
      check("w8_add_done", done8, 1);
      go8(4'b0110, 8'd5, 8'd5);
      check("w8_sub_res", res8, 0);
      check("w8_sub_st", st8, 4'b1010);
      go8(4'b0111, 8'hFF, 8'h01);
      check("w8_slt_res", res8, 1);
      go8(4'b1000, 8'hFF, 8'h02);
      check("w8_mul_res", res8, 0);
      check("w8_mul_st", st8, 4'b1000);
      check("w8_mul_done", done8, 1);
      check("w8_mul_busy", busy8, 0);
      check("w8_mul_hi", hi8, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, legal 8..64.
REQ-002 Parameter MUL_EN, default 1: 1 includes iterative multiplier; 0 treats MULT as illegal op.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0011 SLL, 0100 SRL, 1000 MULT, 0101 HOLD; others illegal.
REQ-008 a, b  in  WIDTH  operands.
REQ-009 shamt  in  clog2(WIDTH)  shift amount for SLL/SRL (shifts b).
REQ-010 result  out  WIDTH  registered result (low word for MULT).
REQ-011 hi  out  WIDTH  registered MULT high word; unchanged by other ops.
REQ-012 status  out  4  {zero, neg, carry, ovf}, registered.
REQ-013 busy  out  1  high while a MULT iterates.
REQ-014 done  out  1  one-cycle pulse when result/status update.

Function
REQ-015 States: IDLE, MUL, FIN; reset enters IDLE.
REQ-016 IDLE, start=1, op single-cycle: latch result/status at that edge, done=1 next cycle, stay IDLE.
REQ-017 IDLE, start=1, op=MULT with MUL_EN=1: latch a, b, clear accumulator, go MUL, busy=1.
REQ-018 MUL: one shift-add step per cycle, unsigned, WIDTH cycles; then FIN.
REQ-019 FIN: write {hi,result}=a*b (2*WIDTH bits), done=1, busy=0, return IDLE; latency start-to-done = WIDTH+1 cycles.
REQ-020 start while busy SHALL be ignored; operands may change freely while busy.
REQ-021 ADD/SUB modulo 2^WIDTH; SUB = a+~b+1; carry = carry-out of that sum; ovf = signed overflow.
REQ-022 SLT: result=1 if signed a<b (uses sign of difference XOR ovf), else 0.
REQ-023 SLL/SRL: logical shift of b by shamt, zero fill; carry=ovf=0.
REQ-024 AND/OR/MULT: carry=ovf=0.
REQ-025 zero = NOR of new result; neg = MSB of new result (MSB of hi for MULT).
REQ-026 HOLD: result, hi, status unchanged; done still pulses.
REQ-027 Illegal op (incl. MULT with MUL_EN=0): result all-zero, status {1,0,0,0}, done pulses.
REQ-028 No combinational path from inputs to any output.

Reset
REQ-029 reset=1 at a clock edge: state IDLE, result=0, hi=0, status=0000, busy=0, done=0.
REQ-030 reset mid-MULT aborts without done; start in same cycle as reset is ignored.

Structure
REQ-031 Shared package alu_pkg holds op encodings, state enum, status bit indices.
REQ-032 Iterative multiplier is one sub-module, alu_mul_iter (start/busy/done, WIDTH parameter); all else in alu_seq.

Verification
REQ-033 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, status {0,1,0,1}, done 1 cycle after start.
REQ-034 SUB a=5 b=5 -> result 0, status {1,0,1,0}; SLT a=0xFFFFFFFF b=1 -> result 1.
REQ-035 MULT a=0xFFFFFFFF b=2 -> busy 32 cycles, done at cycle 33, hi=1, result=0xFFFFFFFE; start pulses during busy ignored.
REQ-036 SLL b=1 shamt=31 -> 0x80000000, neg=1; HOLD afterwards -> outputs unchanged, done pulses.
REQ-037 reset asserted at MUL cycle 10 -> next cycle all outputs zero, no done; new ADD 2+3 then returns 5.
REQ-038 Repeat REQ-033..035 with WIDTH=8 and MUL_EN=0 (MULT -> illegal response per REQ-027).
